// File: rtl/operand_streamer_if.sv
// Operand beat channel between the operand streamer and the datapath controller.
// Valid/ready: a beat transfers on out_valid & out_ready; once out_valid is raised,
// the producer holds every out_* field stable until that transfer happens.
interface operand_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_is_weight;
  logic                  out_half;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_is_weight, out_half, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_is_weight, out_half, out_last,
    output out_ready
  );
endinterface

// File: rtl/operand_streamer.sv
// Walks the convolution loop nest, reads weight/activation words from a 1-cycle memory
// and streams them as valid/ready beats through a small decoupling FIFO.
module operand_streamer #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 20,
  parameter int FEATURE_MAP_WIDTH  = 4,
  parameter int FEATURE_MAP_HEIGHT = 4,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 2,
  parameter int W_BASE             = 0,
  parameter int A_BASE             = 4096,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  operand_streamer_if.master    beat,
  output logic [1:0]            state_dbg
);

  localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int IW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int OW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 3;

  localparam logic [XW-1:0] X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [IW-1:0] CI_MAX = IW'(INPUT_NB_CHANNELS - 1);
  localparam logic [OW-1:0] CO_MAX = OW'(OUTPUT_NB_CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [IW-1:0] ci_q;
  logic [OW-1:0] co_q;
  logic          half_q;
  logic          act_q;

  logic          inflight_q;
  logic          sb_weight_q, sb_half_q, sb_last_q;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          nonempty, push, pop, room, last_pos;
  logic [CW:0]   occupancy;
  logic [EW-1:0] head;
  logic [ADDR_WIDTH-1:0] w_addr, a_addr;

  assign nonempty  = (count_q != '0);
  assign push      = inflight_q;
  assign pop       = nonempty & beat.out_ready;
  // Entries already held plus the one in flight, less the one leaving this cycle.
  assign occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign room      = (occupancy < (CW+1)'(FIFO_DEPTH));
  assign last_pos  = act_q & half_q & (x_q == X_MAX) & (y_q == Y_MAX) &
                     (ci_q == CI_MAX) & (co_q == CO_MAX);

  assign w_addr = ADDR_WIDTH'(W_BASE) +
                  ((ADDR_WIDTH'(ci_q) * ADDR_WIDTH'(OUTPUT_NB_CHANNELS) + ADDR_WIDTH'(co_q)) << 1) +
                  ADDR_WIDTH'(half_q);
  assign a_addr = ADDR_WIDTH'(A_BASE) +
                  (((ADDR_WIDTH'(ci_q) * ADDR_WIDTH'(FEATURE_MAP_WIDTH) + ADDR_WIDTH'(x_q)) *
                    ADDR_WIDTH'(FEATURE_MAP_HEIGHT) + ADDR_WIDTH'(y_q)) << 1) +
                  ADDR_WIDTH'(half_q);

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_re  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        running = 1'b1;
        mem_re  = room;
        if (room && last_pos) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        running = 1'b1;
        if (pop && head[DATA_WIDTH] && (count_q == CW'(1)) && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = mem_re ? (act_q ? a_addr : w_addr) : '0;
  assign state_dbg = state_q;

  // Loop-nest counters; innermost is half, then y, x, the weight/activation phase, ch_out, ch_in.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; half_q <= 1'b0; act_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; half_q <= 1'b0; act_q <= 1'b0;
    end else if (mem_re) begin
      half_q <= ~half_q;
      if (half_q) begin
        if (!act_q) begin
          act_q <= 1'b1;
        end else if (y_q != Y_MAX) begin
          y_q <= y_q + YW'(1);
        end else begin
          y_q <= '0;
          if (x_q != X_MAX) begin
            x_q <= x_q + XW'(1);
          end else begin
            x_q   <= '0;
            act_q <= 1'b0;
            if (co_q != CO_MAX) begin
              co_q <= co_q + OW'(1);
            end else begin
              co_q <= '0;
              ci_q <= (ci_q == CI_MAX) ? '0 : ci_q + IW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      inflight_q  <= 1'b0;
      sb_weight_q <= 1'b0;
      sb_half_q   <= 1'b0;
      sb_last_q   <= 1'b0;
    end else begin
      inflight_q  <= mem_re;
      sb_weight_q <= ~act_q;
      sb_half_q   <= half_q;
      sb_last_q   <= last_pos;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Entry layout: {is_weight, half, last, data}.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {sb_weight_q, sb_half_q, sb_last_q, mem_rdata};
  end

  assign head               = fifo_mem[rd_ptr_q];
  assign beat.out_valid     = nonempty;
  assign beat.out_data      = nonempty ? head[DATA_WIDTH-1:0] : '0;
  assign beat.out_last      = nonempty & head[DATA_WIDTH];
  assign beat.out_half      = nonempty & head[DATA_WIDTH+1];
  assign beat.out_is_weight = nonempty & head[DATA_WIDTH+2];

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: two configurations, data = address memory model.
module tb_operand_streamer;
  localparam int DW = 32;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic arst_in;
  always #5 clk = ~clk;

  logic          start_a, running_a, done_a, mem_re_a;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_rdata_a;
  logic [1:0]    state_a;
  logic          start_b, running_b, done_b, mem_re_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_rdata_b;
  logic [1:0]    state_b;

  operand_streamer_if #(.DATA_WIDTH(DW)) ifa ();
  operand_streamer_if #(.DATA_WIDTH(DW)) ifb ();

  operand_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(2), .W_BASE(0), .A_BASE(100), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .arst_in(arst_in), .start(start_a), .running(running_a), .done(done_a),
    .mem_re(mem_re_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .beat(ifa.master),
    .state_dbg(state_a)
  );

  operand_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .W_BASE(0), .A_BASE(4096), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .arst_in(arst_in), .start(start_b), .running(running_b), .done(done_b),
    .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .beat(ifb.master),
    .state_dbg(state_b)
  );

  // Memory returns its own address one cycle after the read.
  always @(posedge clk) begin
    if (mem_re_a) mem_rdata_a <= DW'(mem_addr_a);
    if (mem_re_b) mem_rdata_b <= DW'(mem_addr_b);
  end

  logic [DW-1:0] seq_a [20] = '{32'd0, 32'd1, 32'd100, 32'd101, 32'd102, 32'd103, 32'd104,
                                32'd105, 32'd106, 32'd107, 32'd2, 32'd3, 32'd100, 32'd101,
                                32'd102, 32'd103, 32'd104, 32'd105, 32'd106, 32'd107};
  logic [DW-1:0] seq_b [4]  = '{32'd0, 32'd1, 32'd4096, 32'd4097};

  int n_cmp = 0;
  int n_bad = 0;

  int            act_d;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   iw_mask;
  int            n_beats, beat_idx, cyc, first_valid, last_cyc, done_cyc, reads, outstanding;
  bit            done_seen, prev_stall;
  logic [DW+2:0] prev_vec;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d);
    if (d == 0) begin
      check("rst_running", running_a, 0);      check("rst_done", done_a, 0);
      check("rst_mem_re", mem_re_a, 0);        check("rst_mem_addr", mem_addr_a, 0);
      check("rst_valid", ifa.out_valid, 0);    check("rst_data", ifa.out_data, 0);
      check("rst_is_weight", ifa.out_is_weight, 0);
      check("rst_half", ifa.out_half, 0);      check("rst_last", ifa.out_last, 0);
      check("rst_state", state_a, 0);
    end else begin
      check("rst_running_b", running_b, 0);    check("rst_done_b", done_b, 0);
      check("rst_mem_re_b", mem_re_b, 0);      check("rst_mem_addr_b", mem_addr_b, 0);
      check("rst_valid_b", ifb.out_valid, 0);  check("rst_data_b", ifb.out_data, 0);
      check("rst_last_b", ifb.out_last, 0);
    end
  endtask

  task automatic track_reset(input int d);
    act_d = d;
    exp_q.delete();
    if (d == 0) begin
      foreach (seq_a[i]) exp_q.push_back(seq_a[i]);
      iw_mask = 32'h0000_0C03;
      n_beats = 20;
    end else begin
      foreach (seq_b[i]) exp_q.push_back(seq_b[i]);
      iw_mask = 32'h0000_0003;
      n_beats = 4;
    end
    beat_idx = 0; cyc = 0; first_valid = -1; last_cyc = -1; done_cyc = -1;
    reads = 0; outstanding = 0; done_seen = 0; prev_stall = 0; prev_vec = '0;
  endtask

  // One clock cycle: drive ready, let combinational paths settle, sample, advance.
  task automatic cycle(input bit rdy);
    logic v, r, iw, hf, lst, re, run, dn;
    logic [DW-1:0] dat;
    logic [AW-1:0] addr;
    ifa.out_ready = (act_d == 0) ? rdy : 1'b1;
    ifb.out_ready = (act_d == 1) ? rdy : 1'b1;
    #1;
    if (act_d == 0) begin
      v = ifa.out_valid; r = ifa.out_ready; dat = ifa.out_data; iw = ifa.out_is_weight;
      hf = ifa.out_half; lst = ifa.out_last; re = mem_re_a; addr = mem_addr_a;
      run = running_a; dn = done_a;
    end else begin
      v = ifb.out_valid; r = ifb.out_ready; dat = ifb.out_data; iw = ifb.out_is_weight;
      hf = ifb.out_half; lst = ifb.out_last; re = mem_re_b; addr = mem_addr_b;
      run = running_b; dn = done_b;
    end
    if (cyc == 1) begin
      check("running_c1", run, 1);
      check("mem_re_c1", re, 1);
      check("mem_addr_c1", addr, 0);
    end
    if (re) begin
      check("re_room", ((outstanding - int'(v && r)) < 4), 1);
      reads++;
    end
    if (prev_stall) begin
      check("stall_valid", v, 1);
      check("stall_hold", {dat, iw, hf, lst}, prev_vec);
    end
    if (v && first_valid < 0) first_valid = cyc;
    if (v && r) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", beat_idx, n_beats - 1);
      end else begin
        check("beat_data", dat, exp_q.pop_front());
        check("beat_is_weight", iw, iw_mask[beat_idx]);
        check("beat_half", hf, beat_idx % 2);
        check("beat_last", lst, (beat_idx == n_beats - 1));
      end
      beat_idx++;
      last_cyc = cyc;
    end
    if (dn) begin
      done_seen = 1;
      done_cyc  = cyc;
      check("running_at_done", run, 0);
    end
    outstanding = outstanding + int'(re) - int'(v && r);
    prev_stall  = v && !r;
    prev_vec    = {dat, iw, hf, lst};
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit random_ready, input int budget);
    int k = 0;
    while (!done_seen && k < budget) begin
      cycle(random_ready ? ($urandom_range(0, 9) < 3) : 1'b1);
      k++;
    end
    check("done_within_budget", done_seen, 1);
  endtask

  task automatic finish_checks();
    check("beat_count", beat_idx, n_beats);
    check("first_valid_cycle", first_valid, 3);
    check("done_after_last", done_cyc, last_cyc + 1);
    check("exp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int r0, k;
    arst_in = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    act_d = 0;
    #2;
    check_zero(0);
    check_zero(1);
    repeat (2) @(posedge clk);
    #1 arst_in = 1'b0;
    @(posedge clk);
    #1;

    // Full stream, consumer always ready.
    track_reset(0);
    start_a = 1'b1; cycle(1'b1); start_a = 1'b0;
    run(1'b0, 200);
    finish_checks();

    // Random backpressure at 30% ready.
    track_reset(0);
    start_a = 1'b1; cycle(1'b1); start_a = 1'b0;
    run(1'b1, 600);
    finish_checks();

    // Ready held low for 10 cycles: buffer fills with exactly 4 reads.
    track_reset(0);
    start_a = 1'b1; cycle(1'b0); start_a = 1'b0;
    repeat (10) cycle(1'b0);
    check("reads_while_stalled", reads, 4);
    check("mem_re_while_full", mem_re_a, 0);
    r0 = reads;
    repeat (4) cycle(1'b1);
    check("burst_after_release", beat_idx, 4);
    check("issue_resumed", reads - r0, 4);
    run(1'b0, 200);
    finish_checks();

    // Reset after beat 7, then a fresh stream.
    track_reset(0);
    start_a = 1'b1; cycle(1'b1); start_a = 1'b0;
    k = 0;
    while (beat_idx < 7 && k < 50) begin cycle(1'b1); k++; end
    check("beats_before_reset", beat_idx, 7);
    arst_in = 1'b1;
    #1;
    check_zero(0);
    @(posedge clk);
    #1 arst_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_reset_no_valid", ifa.out_valid, 0);
      check("post_reset_no_re", mem_re_a, 0);
    end
    track_reset(0);
    start_a = 1'b1; cycle(1'b1); start_a = 1'b0;
    run(1'b0, 200);
    finish_checks();

    // Start held high through the whole stream; re-accepted in the IDLE cycle after done.
    track_reset(0);
    start_a = 1'b1; cycle(1'b1);
    run(1'b0, 200);
    finish_checks();
    check("idle_after_done_running", running_a, 0);
    check("idle_after_done_state", state_a, 0);
    track_reset(0);
    cycle(1'b1);
    start_a = 1'b0;
    run(1'b0, 200);
    finish_checks();

    // Minimal configuration.
    track_reset(1);
    start_b = 1'b1; cycle(1'b1); start_b = 1'b0;
    run(1'b0, 50);
    finish_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
